uart_hex_tx: RTL and testbench



---
 rtl/uart_hex_tx.sv | 191 +++++++++++++++++++
 tb/tb_uart_hex_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_tx.sv
// ---------------------------------------------------------------------------
// uart_hex_tx
//
// Debug UART transmitter. On a one-cycle request it latches a 32-bit debug
// word and sends it as eight uppercase ASCII hex digits, most-significant
// nibble first, followed by CR LF. The serial format is 8N1 with the LSB
// first. A host terminal therefore shows the same value that appears on the
// seven-segment display.
//
// Parameters
//   CLK_FREQ      input clock frequency in Hz
//   BAUD          serial bit rate
//   CLKS_PER_BIT  clock cycles per serial bit (CLK_FREQ/BAUD by default).
//                 It must be >= 2.
//
// Ports
//   CLK100MHZ   in   system clock; the only clock
//   reset       in   synchronous, active-high reset. It has priority mid-frame.
//   send        in   transmit request; sampled only while idle
//   word        in   [31:0] data word; latched on the cycle send is accepted
//   busy        out  high while a frame is in progress
//   done        out  one-cycle pulse in the first idle cycle after a frame
//   tx_pin_out  out  serial line; idle high
//
// All outputs are registered. A frame is 10 characters x 10 bits x
// CLKS_PER_BIT cycles, measured from the first low cycle to the done pulse.
// ---------------------------------------------------------------------------
module uart_hex_tx #(
    parameter int CLK_FREQ     = 100000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        send,
    input  logic [31:0] word,
    output logic        busy,
    output logic        done,
    output logic        tx_pin_out
);

    // The baud counter only needs to reach CLKS_PER_BIT-1.
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [3:0] LAST_CHAR = 4'd9;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;

    logic [1:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [3:0]       char_idx;
    logic [31:0]      word_q;

    logic [3:0]       nibble;
    logic [7:0]       cur_char;
    logic [2:0]       next_bit;
    logic             bit_end;

    // Map one nibble to its uppercase ASCII hex digit.
    // 'A' is 0x41, so the A-F digits are 0x37 + n.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return 8'h37 + {4'h0, n};
    endfunction

    // Select the nibble for the current character, most significant first.
    always_comb begin
        nibble = 4'h0;
        case (char_idx)
            4'd0:    nibble = word_q[31:28];
            4'd1:    nibble = word_q[27:24];
            4'd2:    nibble = word_q[23:20];
            4'd3:    nibble = word_q[19:16];
            4'd4:    nibble = word_q[15:12];
            4'd5:    nibble = word_q[11:8];
            4'd6:    nibble = word_q[7:4];
            4'd7:    nibble = word_q[3:0];
            default: nibble = 4'h0;
        endcase
    end

    // Derive the current character from the latched word and char_idx.
    // Characters 8 and 9 are the CR LF trailer.
    always_comb begin
        cur_char = hex_ascii(nibble);
        if (char_idx == 4'd8)
            cur_char = ASCII_CR;
        else if (char_idx == LAST_CHAR)
            cur_char = ASCII_LF;
    end

    assign next_bit = bit_idx + 3'd1;
    assign bit_end  = (baud_cnt == CNT_MAX);

    // The line level is registered together with the state. Each transition
    // therefore loads the tx level of the state being entered, so the line
    // changes on the same edge as the state.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= 3'd0;
            char_idx   <= 4'd0;
            word_q     <= 32'h0;
            tx_pin_out <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx_pin_out <= 1'b1;
                    busy       <= 1'b0;
                    // This is also the done cycle, which allows back-to-back
                    // frames with a single idle-high cycle between them.
                    if (send) begin
                        word_q     <= word;
                        char_idx   <= 4'd0;
                        bit_idx    <= 3'd0;
                        baud_cnt   <= '0;
                        state      <= START;
                        tx_pin_out <= 1'b0;
                        busy       <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        baud_cnt   <= '0;
                        bit_idx    <= 3'd0;
                        state      <= DATA;
                        tx_pin_out <= cur_char[0];
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state      <= STOP;
                            tx_pin_out <= 1'b1;
                        end else begin
                            bit_idx    <= next_bit;
                            tx_pin_out <= cur_char[next_bit];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (char_idx == LAST_CHAR) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            tx_pin_out <= 1'b1;
                        end else begin
                            // The next start bit follows immediately,
                            // with no inter-character gap.
                            char_idx   <= char_idx + 4'd1;
                            state      <= START;
                            tx_pin_out <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state      <= IDLE;
                    tx_pin_out <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_hex_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_hex_tx
//
// Directed testbench for uart_hex_tx with CLKS_PER_BIT = 4. The line is
// decoded cycle-by-cycle, so each start, data and stop bit is checked for
// its exact width. Expected characters are written out by hand per word.
// ---------------------------------------------------------------------------
module tb_uart_hex_tx;

    localparam int CPB = 4;

    logic        CLK100MHZ = 1'b0;
    logic        reset;
    logic        send;
    logic [31:0] word;
    logic        busy;
    logic        done;
    logic        tx_pin_out;

    int vectors   = 0;
    int errs      = 0;
    int cyc       = 0;
    int done_cnt  = 0;

    uart_hex_tx #(
        .CLK_FREQ    (400),
        .BAUD        (100),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .send      (send),
        .word      (word),
        .busy      (busy),
        .done      (done),
        .tx_pin_out(tx_pin_out)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    always @(posedge CLK100MHZ) cyc <= cyc + 1;
    always @(negedge CLK100MHZ) if (done) done_cnt <= done_cnt + 1;

    task automatic tick();
        @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entry point: the first cycle of a start bit. Exit point: the cycle
    // after the last stop cycle. Any bit of the wrong width, or busy
    // dropping mid-character, is counted in bad.
    task automatic rx_char(input bit pulse, output logic [7:0] b, output int bad);
        logic v;
        bad = 0;
        for (int i = 0; i < CPB; i++) begin
            if (tx_pin_out !== 1'b0 || busy !== 1'b1) bad++;
            tick();
            if (pulse && i == 0) send = 1'b0;
        end
        for (int k = 0; k < 8; k++) begin
            v = tx_pin_out;
            b[k] = v;
            for (int i = 0; i < CPB; i++) begin
                if (tx_pin_out !== v || busy !== 1'b1) bad++;
                tick();
            end
        end
        for (int i = 0; i < CPB; i++) begin
            if (tx_pin_out !== 1'b1 || busy !== 1'b1) bad++;
            tick();
        end
    endtask

    // Entry point: the first low cycle of a frame. Exit point: the done cycle.
    // If pulse_at >= 0, send is pulsed with pulse_word at the start of that
    // character.
    task automatic rx_frame(input string tag, input logic [79:0] exp,
                            input int pulse_at, input logic [31:0] pulse_word);
        logic [7:0] b;
        int bad;
        int bad_total;
        int t0;
        t0 = cyc;
        bad_total = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == pulse_at) begin
                send = 1'b1;
                word = pulse_word;
            end
            rx_char(k == pulse_at, b, bad);
            bad_total += bad;
            check($sformatf("%s char%0d", tag, k), {24'h0, b}, {24'h0, exp[79-8*k -: 8]});
        end
        check({tag, " framing"}, bad_total, 0);
        check({tag, " done"}, {31'h0, done}, 1);
        check({tag, " busy@done"}, {31'h0, busy}, 0);
        check({tag, " tx@done"}, {31'h0, tx_pin_out}, 1);
        check({tag, " length"}, cyc - t0, 100 * CPB);
    endtask

    task automatic start_frame(input string tag, input logic [31:0] w);
        word = w;
        send = 1'b1;
        tick();
        send = 1'b0;
        check({tag, " latency tx"}, {31'h0, tx_pin_out}, 0);
        check({tag, " latency busy"}, {31'h0, busy}, 1);
    endtask

    initial begin
        logic [7:0] b;
        int bad;
        int dc0;
        int lows;

        reset = 1'b1;
        send  = 1'b0;
        word  = 32'h0;

        // Reset for three cycles
        repeat (3) tick();
        check("reset tx", {31'h0, tx_pin_out}, 1);
        check("reset busy", {31'h0, busy}, 0);
        check("reset done", {31'h0, done}, 0);
        reset = 1'b0;
        tick();

        // Basic frame
        dc0 = done_cnt;
        start_frame("t1", 32'h1234ABCD);
        rx_frame("t1", 80'h31323334414243440D0A, -1, 32'h0);
        tick();
        check("t1 done cleared", {31'h0, done}, 0);
        check("t1 idle tx", {31'h0, tx_pin_out}, 1);
        check("t1 done count", done_cnt - dc0, 1);

        // All-zero and all-one digits
        start_frame("t2a", 32'h00000000);
        rx_frame("t2a", 80'h30303030303030300D0A, -1, 32'h0);
        tick();
        tick();
        start_frame("t2b", 32'hFFFFFFFF);
        rx_frame("t2b", 80'h46464646464646460D0A, -1, 32'h0);
        tick();

        // A send while busy is ignored and not queued
        dc0 = done_cnt;
        start_frame("t3", 32'h11111111);
        rx_frame("t3", 80'h31313131313131310D0A, 3, 32'h22222222);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx_pin_out !== 1'b1 || busy !== 1'b0) lows++;
        end
        check("t3 no second frame", lows, 0);
        check("t3 done count", done_cnt - dc0, 1);

        // Reset mid-frame, during DATA of char 3
        start_frame("t4a", 32'h12345678);
        rx_char(1'b0, b, bad);
        check("t4a char0", {24'h0, b}, 32'h31);
        rx_char(1'b0, b, bad);
        check("t4a char1", {24'h0, b}, 32'h32);
        rx_char(1'b0, b, bad);
        check("t4a char2", {24'h0, b}, 32'h33);
        repeat (CPB + 2 * CPB + 1) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t4 reset tx", {31'h0, tx_pin_out}, 1);
        check("t4 reset busy", {31'h0, busy}, 0);
        check("t4 reset done", {31'h0, done}, 0);
        lows = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_pin_out !== 1'b1 || done !== 1'b0) lows++;
        end
        check("t4 line quiet after reset", lows, 0);
        start_frame("t4b", 32'hDEADBEEF);
        rx_frame("t4b", 80'h44454144424545460D0A, -1, 32'h0);
        tick();

        // Back-to-back frames with send held high
        dc0 = done_cnt;
        word = 32'hCAFE0001;
        send = 1'b1;
        tick();
        check("t5 latency tx", {31'h0, tx_pin_out}, 0);
        rx_frame("t5a", 80'h43414645303030310D0A, -1, 32'h0);
        tick();
        check("t5 restart tx", {31'h0, tx_pin_out}, 0);
        check("t5 restart busy", {31'h0, busy}, 1);
        check("t5 restart done", {31'h0, done}, 0);
        rx_frame("t5b", 80'h43414645303030310D0A, -1, 32'h0);
        send = 1'b0;
        tick();
        check("t5 stop tx", {31'h0, tx_pin_out}, 1);
        check("t5 stop busy", {31'h0, busy}, 0);
        check("t5 done count", done_cnt - dc0, 2);

        // Reset and send asserted together: reset wins
        reset = 1'b1;
        send  = 1'b1;
        tick();
        check("t5 rst+send tx", {31'h0, tx_pin_out}, 1);
        check("t5 rst+send busy", {31'h0, busy}, 0);
        tick();
        check("t5 rst+send tx2", {31'h0, tx_pin_out}, 1);
        reset = 1'b0;
        send  = 1'b0;
        tick();
        check("t5 after rst tx", {31'h0, tx_pin_out}, 1);
        check("t5 after rst busy", {31'h0, busy}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
